// File: rtl/grad_div_feeder.sv
// grad_div_feeder: buffers signed gradient pairs (gx, gy) in a 2-entry FIFO,
// orders their magnitudes into min/max operands for an external divider, and
// returns the divider quotient together with the octant bits.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_gx, in_gy      : gradient sample input handshake
//   div_enable, g_dividend_Q, g_divider_Q: divider request (level-held enable)
//   div_quotient, div_ready              : divider response
//   out_valid/out_ready, out_quotient,
//   out_octant {gx_neg, gy_neg, swap}, out_err (divider timeout)
module grad_div_feeder #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_gx,
  input  logic [15:0] in_gy,
  output logic        in_ready,
  output logic        div_enable,
  output logic [15:0] g_dividend_Q,
  output logic [15:0] g_divider_Q,
  input  logic [7:0]  div_quotient,
  input  logic        div_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_quotient,
  output logic [2:0]  out_octant,
  output logic        out_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    mem_q [2];
  logic           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]     count_q, count_d;
  logic           in_ready_q, in_ready_d;
  logic           div_en_q, div_en_d;
  logic [15:0]    dividend_q, dividend_d, divider_q, divider_d;
  logic           valid_q, valid_d;
  logic [7:0]     quot_q, quot_d;
  logic [2:0]     oct_q, oct_d;
  logic           err_q, err_d;
  logic [CW-1:0]  wait_q, wait_d;

  logic           push, pop;
  logic [15:0]    head_gx, head_gy, mag_gx, mag_gy, mag_min, mag_max;
  logic           swap;

  function automatic logic [15:0] mag(input logic [15:0] v);
    if (!v[15])              return v;
    else if (v == 16'h8000)  return 16'h7FFF;
    else                     return 16'h0000 - v;
  endfunction

  assign head_gx = mem_q[rd_ptr_q][31:16];
  assign head_gy = mem_q[rd_ptr_q][15:0];
  assign mag_gx  = mag(head_gx);
  assign mag_gy  = mag(head_gy);
  assign swap    = (mag_gy > mag_gx);
  assign mag_min = swap ? mag_gx : mag_gy;
  assign mag_max = swap ? mag_gy : mag_gx;

  // in_ready is registered so it reads 0 throughout reset and rises at the
  // first edge after release.
  assign push = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    div_en_d   = div_en_q;
    dividend_d = dividend_q;
    divider_d  = divider_q;
    valid_d    = valid_q;
    quot_d     = quot_q;
    oct_d      = oct_q;
    err_d      = err_q;
    wait_d     = wait_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop   = 1'b1;
          oct_d = {head_gx[15], head_gy[15], swap};
          if (mag_max != 16'd0) begin
            dividend_d = mag_min;
            divider_d  = mag_max;
            div_en_d   = 1'b1;
            wait_d     = '0;
            state_d    = WAIT;
          end else begin
            quot_d  = '0;
            err_d   = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        // wait_q == 0 marks the first WAIT cycle, where div_ready may be stale.
        if (wait_q != '0 && div_ready) begin
          quot_d   = div_quotient;
          err_d    = 1'b0;
          div_en_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          quot_d   = '1;
          err_d    = 1'b1;
          div_en_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: begin
        div_en_d = 1'b0;
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    in_ready_d = (count_d < 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      div_en_q   <= 1'b0;
      dividend_q <= '0;
      divider_q  <= '0;
      valid_q    <= 1'b0;
      quot_q     <= '0;
      oct_q      <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      if (push) mem_q[wr_ptr_q] <= {in_gx, in_gy};
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      div_en_q   <= div_en_d;
      dividend_q <= dividend_d;
      divider_q  <= divider_d;
      valid_q    <= valid_d;
      quot_q     <= quot_d;
      oct_q      <= oct_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign div_enable   = div_en_q;
  assign g_dividend_Q = dividend_q;
  assign g_divider_Q  = divider_q;
  assign out_valid    = valid_q;
  assign out_quotient = quot_q;
  assign out_octant   = oct_q;
  assign out_err      = err_q;

endmodule
